// File: rtl/fir_pkg.sv
// Shared constants, coefficient table and FSM state type for the half-band decimating FIR.
package fir_pkg;

  localparam int unsigned NDefault = 16;
  localparam int unsigned WDefault = 8;
  localparam int unsigned HDefault = 8;

  localparam int Coef [16] = '{0, 0, 3, 0, -15, 0, 73, 126, 80, 0, -20, 0, 6, 0, -1, 0};

  typedef enum logic [1:0] {
    StLoad,
    StMac,
    StHold
  } state_e;

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate; sum_o is the running total including the current product.
module fir_mac #(
  parameter int unsigned AW   = 9,
  parameter int unsigned BW   = 9,
  parameter int unsigned AccW = 21
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [AW-1:0]   a_i,
  input  logic [BW-1:0]   b_i,
  output logic [AccW-1:0] sum_o
);

  logic signed [AW+BW-1:0] prod;
  logic signed [AccW-1:0]  acc_q, acc_d;

  assign prod  = $signed(a_i) * $signed(b_i);
  assign sum_o = acc_q + AccW'(prod);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fir_decim2.sv
// Decimate-by-2 FIR: loads two samples, runs one tap per cycle on a shared MAC, then holds the result.
module fir_decim2
  import fir_pkg::*;
#(
  parameter int unsigned N = NDefault,
  parameter int unsigned W = WDefault,
  parameter int unsigned H = HDefault
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [W:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W+N-1:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned KW   = $clog2(N);
  localparam int unsigned AccW = W + H + 5;

  state_e               state_q, state_d;
  logic                 phase_q, phase_d;
  logic [KW-1:0]        k_q, k_d;
  logic [W+N-1:0]       out_q, out_d;
  logic signed [W:0]    x_q [N];
  logic                 shift, mac_clr, mac_en;
  logic signed [H:0]    coef;
  logic [AccW-1:0]      mac_sum;
  logic signed [AccW-1:0] y_shift;

  assign coef    = (H+1)'(Coef[k_q]);
  assign y_shift = $signed(mac_sum) >>> H;

  fir_mac #(
    .AW   (W + 1),
    .BW   (H + 1),
    .AccW (AccW)
  ) u_mac (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .a_i    (x_q[k_q]),
    .b_i    (coef),
    .sum_o  (mac_sum)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    k_d       = k_q;
    out_d     = out_q;
    shift     = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift   = 1'b1;
          phase_d = ~phase_q;
          if (phase_q) begin
            state_d = StMac;
            mac_clr = 1'b1;
            k_d     = '0;
          end
        end
      end
      StMac: begin
        mac_en = 1'b1;
        k_d    = k_q + KW'(1);
        if (k_q == KW'(N - 1)) begin
          state_d = StHold;
          k_d     = '0;
          // sum_o already includes the last tap, so the result is captured on this edge.
          out_d   = (W+N)'(y_shift);
        end
      end
      StHold: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StLoad;
      phase_q <= 1'b0;
      k_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      k_q     <= k_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        x_q[i] <= '0;
      end
    end else if (shift) begin
      x_q[0] <= in_data;
      for (int i = 1; i < N; i++) begin
        x_q[i] <= x_q[i-1];
      end
    end
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_fir_decim2.sv
// Self-checking bench for fir_decim2 with directed vectors and a sum-of-products reference model.
module tb_fir_decim2;

  localparam int N = 16;
  localparam int W = 8;
  localparam int H = 8;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [W:0]     in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W+N-1:0] out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  int h_ref [16] = '{0, 0, 3, 0, -15, 0, 73, 126, 80, 0, -20, 0, 6, 0, -1, 0};
  int hist[$];
  bit phase_m;
  int exp_q[$];
  int got_q[$];

  always #5 clock = ~clock;

  fir_decim2 dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  function automatic int out_int();
    return int'($signed(out_data));
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < N; i++) hist.push_back(0);
    phase_m = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  // y = sum h[k]*x[k] over the line after the shift, floored by 2^H.
  task automatic model_push(input int v, output bit trig);
    int y;
    hist.push_front(v);
    void'(hist.pop_back());
    trig    = phase_m;
    phase_m = ~phase_m;
    if (trig) begin
      y = 0;
      for (int k = 0; k < N; k++) y += h_ref[k] * hist[k];
      exp_q.push_back(y >>> H);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    model_reset();
  endtask

  task automatic rand_sample(output int v);
    v = int'($urandom_range(0, 511)) - 256;
  endtask

  // Transfers one sample; on a triggering sample, collects the resulting output.
  task automatic feed(input int v);
    int n;
    bit trig;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL feed_in_ready_timeout: in_ready=%0b, required 1", in_ready);
    end else begin
      in_valid = 1'b1;
      in_data  = v[W:0];
      step();
      in_valid = 1'b0;
      model_push(v, trig);
      if (trig) begin
        n = 0;
        while (!out_valid && n < 40) begin
          step();
          n++;
        end
        if (!out_valid) begin
          checks++;
          errors++;
          $display("FAIL feed_out_valid_timeout: out_valid=%0b, required 1", out_valid);
        end else begin
          got_q.push_back(out_int());
          step();
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %0b, required 0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_out_data: got %0d, required 0", out_int());
    end
    do_reset();
  endtask

  task automatic test_impulse(input string tag);
    int imp_exp [9] = '{0, 1, -8, 36, 40, -10, 3, -1, 0};
    feed(0);
    feed(128);
    for (int i = 0; i < 16; i++) feed(0);
    checks++;
    if (got_q.size() != 9) begin
      errors++;
      $display("FAIL %s_count: got %0d outputs, required 9", tag, got_q.size());
    end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] != imp_exp[i]) begin
        errors++;
        $display("FAIL %s_out%0d: got %0d, required %0d", tag, i, got_q[i], imp_exp[i]);
      end
    end
  endtask

  task automatic test_odd_impulse();
    int odd_exp [8] = '{0, 0, 0, 63, 0, 0, 0, 0};
    do_reset();
    feed(128);
    for (int i = 0; i < 15; i++) feed(0);
    checks++;
    if (got_q.size() != 8) begin
      errors++;
      $display("FAIL odd_count: got %0d outputs, required 8", got_q.size());
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] != odd_exp[i]) begin
        errors++;
        $display("FAIL odd_out%0d: got %0d, required %0d", i, got_q[i], odd_exp[i]);
      end
    end
  endtask

  task automatic test_dc();
    do_reset();
    for (int i = 0; i < 32; i++) feed(255);
    for (int i = 0; i < 32; i++) feed(-256);
    checks++;
    if (got_q.size() != 32) begin
      errors++;
      $display("FAIL dc_count: got %0d outputs, required 32", got_q.size());
    end
    for (int i = 8; i < 16 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] != 251) begin
        errors++;
        $display("FAIL dc_pos_out%0d: got %0d, required 251", i, got_q[i]);
      end
    end
    for (int i = 24; i < 32 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] != -252) begin
        errors++;
        $display("FAIL dc_neg_out%0d: got %0d, required -252", i, got_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int v;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      rand_sample(v);
      feed(v);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d outputs, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL rand_out%0d: got %0d, required %0d", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int a, b, n, held, v;
    bit trig;
    do_reset();
    out_ready = 1'b0;
    rand_sample(a);
    rand_sample(b);
    in_valid = 1'b1;
    in_data  = a[W:0];
    step();
    in_data = b[W:0];
    step();
    in_valid = 1'b0;
    model_push(a, trig);
    model_push(b, trig);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    held = out_int();
    checks++;
    if (out_valid !== 1'b1 || held != exp_q[0]) begin
      errors++;
      $display("FAIL bp_first: valid=%0b data=%0d, required valid=1 data=%0d",
               out_valid, held, exp_q[0]);
    end
    for (int i = 0; i < 10; i++) begin
      rand_sample(v);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = v[W:0];
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_int() != held) begin
        errors++;
        $display("FAIL bp_stall%0d: valid=%0b ready=%0b data=%0d, required 1 0 %0d",
                 i, out_valid, in_ready, out_int(), held);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_int() != held) begin
      errors++;
      $display("FAIL bp_release: valid=%0b data=%0d, required 0 %0d", out_valid, out_int(), held);
    end
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      rand_sample(v);
      feed(v);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_q.size() || i >= exp_q.size() || got_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL bp_after%0d: got %0d, required %0d", i,
                 (i < got_q.size()) ? got_q[i] : 99999, (i < exp_q.size()) ? exp_q[i] : 99999);
      end
    end
  endtask

  task automatic test_back_to_back();
    int accepted, t_trig, t_v1, t_v2, v;
    bit prev_ov, trig;
    do_reset();
    accepted = 0;
    t_trig   = -1;
    t_v1     = -1;
    t_v2     = -1;
    prev_ov  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rand_sample(v);
      in_data = v[W:0];
      if (out_valid && !prev_ov) begin
        if (t_v1 < 0) t_v1 = i;
        else if (t_v2 < 0) t_v2 = i;
      end
      prev_ov = out_valid;
      if (out_valid) got_q.push_back(out_int());
      if (in_ready) begin
        accepted++;
        if (accepted == 2) t_trig = i;
        model_push(v, trig);
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (t_v1 - t_trig != 17) begin
      errors++;
      $display("FAIL b2b_latency: got %0d cycles, required 17", t_v1 - t_trig);
    end
    checks++;
    if (t_v2 - t_v1 != 19) begin
      errors++;
      $display("FAIL b2b_period: got %0d cycles, required 19", t_v2 - t_v1);
    end
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d outputs, required 3", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL b2b_out%0d: got %0d, required %0d", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    do_reset();
    feed(0);
    in_valid = 1'b1;
    in_data  = 9'd128;
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mac_busy: in_ready=%0b out_valid=%0b, required 0 0", in_ready, out_valid);
    end
    repeat (5) step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      errors++;
      $display("FAIL mid_reset: valid=%0b ready=%0b data=%0d, required 0 1 0",
               out_valid, in_ready, out_int());
    end
    repeat (2) step();
    reset_n = 1'b1;
    step();
    model_reset();
    test_impulse("rerun");
  endtask

  initial begin
    test_reset();
    test_impulse("impulse");
    test_odd_impulse();
    test_dc();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mac();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
